// File: rtl/i2s_tx.sv
// i2s_tx: Philips-format I2S serializer (transmit side).
//
// Takes one stereo sample pair per frame over a valid/ready handshake,
// holds it in a one-pair buffer, and shifts it out MSB-first with the
// standard one-bit delay after each WS edge. Every channel slot is
// SLOT_BITS bit clocks long. Samples narrower than the slot are padded
// with zeros after the LSB.
//
// The parent drives sclk_i from the inverted bus SCLK. All outputs
// therefore change on the bus falling edge, and the receiver samples
// them mid-bit.
//
// Ports:
//   sclk_i        bit clock; all state updates on its rising edge
//   rst_n_i       asynchronous active-low reset
//   leftChan_i    left sample (two's complement, WIDTH bits)
//   rightChan_i   right sample (WIDTH bits)
//   pktValid_i    a sample pair is offered
//   pktReady_o    the buffer can accept a pair (buffer empty)
//   ws_o          word select: 0 = left slot, 1 = right slot
//   sdata_o       serial data
//   frameStart_o  one-cycle pulse coincident with the ws_o falling edge
//   underrun_o    one-cycle pulse when a frame starts with no buffered pair

module i2s_tx #(
  parameter int WIDTH     = 16,
  parameter int SLOT_BITS = 32
) (
  input  logic             sclk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] leftChan_i,
  input  logic [WIDTH-1:0] rightChan_i,
  input  logic             pktValid_i,
  output logic             pktReady_o,
  output logic             ws_o,
  output logic             sdata_o,
  output logic             frameStart_o,
  output logic             underrun_o
);

  localparam int FRAME = 2 * SLOT_BITS;
  localparam int CW    = $clog2(FRAME);
  localparam int IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CW-1:0] LAST_C  = CW'(FRAME - 1);
  localparam logic [CW-1:0] SLOT_C  = CW'(SLOT_BITS);
  localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bufFull_q, bufFull_d;
  logic [WIDTH-1:0] bufLeft_q, bufLeft_d;
  logic [WIDTH-1:0] bufRight_q, bufRight_d;
  logic [WIDTH-1:0] txLeft_q, txLeft_d;
  logic [WIDTH-1:0] txRight_q, txRight_d;
  logic             ws_q, ws_d;
  logic             sdata_q, sdata_d;
  logic             frameStart_q, frameStart_d;
  logic             underrun_q, underrun_d;

  logic             frameEdge;
  logic             accept;
  logic [CW-1:0]    bitPos;
  logic [CW-1:0]    rightPos;
  logic [IW-1:0]    leftIdx;
  logic [IW-1:0]    rightIdx;

  assign frameEdge = (cnt_q == '0);
  assign accept    = pktValid_i && !bufFull_q;

  // Frame bit emitted on this edge is the one belonging to cnt-1. At cnt=0
  // that wraps to the last bit of the previous frame. That bit still comes
  // from the old txRight, because the reload only takes effect after this edge.
  assign bitPos   = frameEdge ? LAST_C : (cnt_q - ONE_C);
  assign rightPos = bitPos - SLOT_C;

  // Select the serial bit for bitPos. Slot positions past the sample width are zero padding.
  always_comb begin
    sdata_d  = 1'b0;
    leftIdx  = '0;
    rightIdx = '0;
    if (bitPos < WIDTH_C) begin
      leftIdx = IW'(WIDTH - 1) - bitPos[IW-1:0];
      sdata_d = txLeft_q[leftIdx];
    end else if ((bitPos >= SLOT_C) && (rightPos < WIDTH_C)) begin
      rightIdx = IW'(WIDTH - 1) - rightPos[IW-1:0];
      sdata_d  = txRight_q[rightIdx];
    end
  end

  // Counter, WS and frame-start / underrun pulses for the current cnt.
  always_comb begin
    cnt_d        = (cnt_q == LAST_C) ? '0 : (cnt_q + ONE_C);
    ws_d         = (cnt_q >= SLOT_C);
    frameStart_d = frameEdge;
    underrun_d   = frameEdge && !bufFull_q;
  end

  // One-pair buffer and the transmit registers.
  // A drain and an accept never happen on the same edge, because accepting
  // requires an empty buffer. A pair accepted on the frame edge therefore
  // waits for the following frame and does not bypass into the current one.
  always_comb begin
    bufFull_d  = bufFull_q;
    bufLeft_d  = bufLeft_q;
    bufRight_d = bufRight_q;
    txLeft_d   = txLeft_q;
    txRight_d  = txRight_q;
    if (frameEdge) begin
      if (bufFull_q) begin
        txLeft_d  = bufLeft_q;
        txRight_d = bufRight_q;
        bufFull_d = 1'b0;
      end else begin
        txLeft_d  = '0;
        txRight_d = '0;
      end
    end
    if (accept) begin
      bufLeft_d  = leftChan_i;
      bufRight_d = rightChan_i;
      bufFull_d  = 1'b1;
    end
  end

  // State register. Reset parks WS high, so the first frame edge after
  // release produces the falling WS edge.
  always_ff @(posedge sclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q        <= '0;
      bufFull_q    <= 1'b0;
      bufLeft_q    <= '0;
      bufRight_q   <= '0;
      txLeft_q     <= '0;
      txRight_q    <= '0;
      ws_q         <= 1'b1;
      sdata_q      <= 1'b0;
      frameStart_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      bufFull_q    <= bufFull_d;
      bufLeft_q    <= bufLeft_d;
      bufRight_q   <= bufRight_d;
      txLeft_q     <= txLeft_d;
      txRight_q    <= txRight_d;
      ws_q         <= ws_d;
      sdata_q      <= sdata_d;
      frameStart_q <= frameStart_d;
      underrun_q   <= underrun_d;
    end
  end

  assign pktReady_o   = ~bufFull_q;
  assign ws_o         = ws_q;
  assign sdata_o      = sdata_q;
  assign frameStart_o = frameStart_q;
  assign underrun_o   = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: directed, table-driven bench for i2s_tx.
//
// dut1 uses WIDTH=16, SLOT_BITS=32 (64-clock frame).
// dut2 uses WIDTH=16, SLOT_BITS=16 (32-clock frame), where the delay bit
// at cnt=0 carries the previous right LSB.
// Both instances share the clock and reset. After each reset release the
// first edge is cnt=0 for both, so the bench tracks their counters from a
// single edge index.

module tb_i2s_tx;

  logic        clk;
  logic        rst_n;
  logic [15:0] left1, right1, left2, right2;
  logic        valid1, valid2;
  logic        ready1, ws1, sdata1, fs1, ur1;
  logic        ready2, ws2, sdata2, fs2, ur2;

  int checks = 0;
  int errors = 0;
  int cycle  = -1;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic [63:0] expSerial;
  } vec_t;

  vec_t vecs[5];

  i2s_tx #(.WIDTH(16), .SLOT_BITS(32)) dut1 (
    .sclk_i(clk), .rst_n_i(rst_n), .leftChan_i(left1), .rightChan_i(right1),
    .pktValid_i(valid1), .pktReady_o(ready1), .ws_o(ws1), .sdata_o(sdata1),
    .frameStart_o(fs1), .underrun_o(ur1)
  );

  i2s_tx #(.WIDTH(16), .SLOT_BITS(16)) dut2 (
    .sclk_i(clk), .rst_n_i(rst_n), .leftChan_i(left2), .rightChan_i(right2),
    .pktValid_i(valid2), .pktReady_o(ready2), .ws_o(ws2), .sdata_o(sdata2),
    .frameStart_o(fs2), .underrun_o(ur2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
    cycle = cycle + 1;
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] l, input logic [15:0] r);
    valid1 = v;
    left1  = l;
    right1 = r;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Step until the last edge used cnt == target (modulo frame length).
  task automatic waitCnt(input int target, input int frameLen);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if ((cycle % frameLen) == target) found = 1'b1;
      else tick();
    end
    checkOutput("waitCntReached", 64'(found), 64'd1);
  endtask

  // Capture n serial bits MSB-first, starting at the next edge. Valids are
  // dropped after the first edge, so at most one pair is accepted in here.
  task automatic collect(input int n, input bit sel, output logic [63:0] ser,
                         output logic [63:0] wsv, output int fsN, output int urN);
    ser = '0;
    wsv = '0;
    fsN = 0;
    urN = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (i == 0) begin
        valid1 = 1'b0;
        valid2 = 1'b0;
      end
      ser = {ser[62:0], (sel ? sdata2 : sdata1)};
      wsv = {wsv[62:0], (sel ? ws2 : ws1)};
      fsN = fsN + int'(sel ? fs2 : fs1);
      urN = urN + int'(sel ? ur2 : ur1);
    end
  endtask

  initial begin
    logic [63:0] ser, wsv;
    int fsN, urN;

    vecs[0] = '{16'hA5C3, 16'h0F0F, 64'hA5C3_0000_0F0F_0000};
    vecs[1] = '{16'hFFFF, 16'h0000, 64'hFFFF_0000_0000_0000};
    vecs[2] = '{16'h0000, 16'hFFFF, 64'h0000_0000_FFFF_0000};
    vecs[3] = '{16'h8001, 16'h7FFE, 64'h8001_0000_7FFE_0000};
    vecs[4] = '{16'h1234, 16'hABCD, 64'h1234_0000_ABCD_0000};

    // Reset with a pair offered: it must be ignored.
    rst_n  = 1'b0;
    valid2 = 1'b0;
    left2  = '0;
    right2 = '0;
    applyStimulus(1'b1, 16'hDEAD, 16'hBEEF);
    tick();
    tick();
    checkOutput("rstWs", 64'(ws1), 64'd1);
    checkOutput("rstSdata", 64'(sdata1), 64'd0);
    checkOutput("rstFrameStart", 64'(fs1), 64'd0);
    checkOutput("rstUnderrun", 64'(ur1), 64'd0);
    checkOutput("rstReady", 64'(ready1), 64'd1);
    applyStimulus(1'b0, 16'h0, 16'h0);
    rst_n = 1'b1;
    cycle = -1;

    // First edge is cnt=0 with an empty buffer.
    tick();
    checkOutput("firstEdgeFs", 64'(fs1), 64'd1);
    checkOutput("firstEdgeUr", 64'(ur1), 64'd1);
    checkOutput("firstEdgeWs", 64'(ws1), 64'd0);

    // Idle frame: silent data, 32/32 WS pattern, one pulse of each kind.
    collect(64, 1'b0, ser, wsv, fsN, urN);
    checkOutput("idleSerial", ser, 64'h0);
    checkOutput("idleWs", wsv, 64'h0000_0001_FFFF_FFFE);
    checkOutput("idleFsCount", 64'(fsN), 64'd1);
    checkOutput("idleUrCount", 64'(urN), 64'd1);

    // Table: offer a pair at cnt=63, it loads at cnt=0, then serialize.
    for (int v = 0; v < 5; v++) begin
      waitCnt(62, 64);
      applyStimulus(1'b1, vecs[v].l, vecs[v].r);
      tick();
      checkOutput("vecReadyLow", 64'(ready1), 64'd0);
      applyStimulus(1'b0, 16'h0, 16'h0);
      tick();
      checkOutput("vecFrameStart", 64'(fs1), 64'd1);
      checkOutput("vecNoUnderrun", 64'(ur1), 64'd0);
      collect(64, 1'b0, ser, wsv, fsN, urN);
      checkOutput("vecSerial", ser, vecs[v].expSerial);
      checkOutput("vecWs", wsv, 64'h0000_0001_FFFF_FFFE);
    end

    // Back-to-back: P2 waits for the buffer to drain at the next frame edge.
    waitCnt(10, 64);
    applyStimulus(1'b1, 16'h1357, 16'h2468);
    tick();
    checkOutput("b2bP1Accepted", 64'(ready1), 64'd0);
    applyStimulus(1'b1, 16'hFEDC, 16'h0001);
    waitCnt(63, 64);
    checkOutput("b2bReadyHeld", 64'(ready1), 64'd0);
    tick();
    checkOutput("b2bNoUnderrun1", 64'(ur1), 64'd0);
    checkOutput("b2bReadyRises", 64'(ready1), 64'd1);
    collect(64, 1'b0, ser, wsv, fsN, urN);
    checkOutput("b2bSerialP1", ser, 64'h1357_0000_2468_0000);
    checkOutput("b2bNoUnderrun2", 64'(ur1), 64'd0);
    collect(64, 1'b0, ser, wsv, fsN, urN);
    checkOutput("b2bSerialP2", ser, 64'hFEDC_0000_0001_0000);

    // Pair offered on the frame edge with an empty buffer: the current
    // frame is muted and the pair goes out in the next one.
    waitCnt(63, 64);
    applyStimulus(1'b1, 16'hC001, 16'h3FFC);
    tick();
    checkOutput("lateUnderrun", 64'(ur1), 64'd1);
    checkOutput("lateFrameStart", 64'(fs1), 64'd1);
    checkOutput("lateAccepted", 64'(ready1), 64'd0);
    applyStimulus(1'b0, 16'h0, 16'h0);
    collect(64, 1'b0, ser, wsv, fsN, urN);
    checkOutput("lateMutedFrame", ser, 64'h0);
    checkOutput("lateNoUnderrun", 64'(ur1), 64'd0);
    collect(64, 1'b0, ser, wsv, fsN, urN);
    checkOutput("lateSerial", ser, 64'hC001_0000_3FFC_0000);

    // Asynchronous reset mid-frame with the buffer full.
    waitCnt(62, 64);
    applyStimulus(1'b1, 16'hFFFF, 16'h0000);
    tick();
    applyStimulus(1'b0, 16'h0, 16'h0);
    tick();
    applyStimulus(1'b1, 16'h5555, 16'h5555);
    tick();
    applyStimulus(1'b0, 16'h0, 16'h0);
    waitCnt(10, 64);
    checkOutput("preRstSdata", 64'(sdata1), 64'd1);
    checkOutput("preRstWs", 64'(ws1), 64'd0);
    checkOutput("preRstBufFull", 64'(ready1), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncRstWs", 64'(ws1), 64'd1);
    checkOutput("asyncRstSdata", 64'(sdata1), 64'd0);
    checkOutput("asyncRstReady", 64'(ready1), 64'd1);
    tick();
    rst_n = 1'b1;
    cycle = -1;
    tick();
    checkOutput("postRstFs", 64'(fs1), 64'd1);
    checkOutput("postRstUr", 64'(ur1), 64'd1);
    checkOutput("postRstWs", 64'(ws1), 64'd0);
    collect(64, 1'b0, ser, wsv, fsN, urN);
    checkOutput("postRstSerial", ser, 64'h0);

    // SLOT_BITS == WIDTH: the delay bit at cnt=0 is the previous right LSB.
    waitCnt(30, 32);
    valid2 = 1'b1;
    left2  = 16'h8001;
    right2 = 16'h7FFE;
    tick();
    checkOutput("s16Accepted", 64'(ready2), 64'd0);
    valid2 = 1'b0;
    tick();
    checkOutput("s16NoUnderrun1", 64'(ur2), 64'd0);
    valid2 = 1'b1;
    left2  = 16'h0000;
    right2 = 16'hFFFF;
    collect(32, 1'b1, ser, wsv, fsN, urN);
    checkOutput("s16Serial1", ser, 64'h0000_0000_8001_7FFE);
    checkOutput("s16NoUnderrun2", 64'(ur2), 64'd0);
    collect(32, 1'b1, ser, wsv, fsN, urN);
    checkOutput("s16Serial2", ser, 64'h0000_0000_0000_FFFF);
    checkOutput("s16DelayBit", 64'(sdata2), 64'd1);
    checkOutput("s16Underrun", 64'(ur2), 64'd1);
    checkOutput("s16FsCount", 64'(fsN), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- I2S serializer paired with I2Srx; sits between the audio processing path and the pad-level SDATA/WS pins.
- Accepts one stereo sample pair per frame over a valid/ready handshake and buffers one pair.
- Drives Philips-format WS and SDATA: MSB-first, one-bit delay after the WS edge, fixed-length slots.
- Runs in the bit-clock domain. Top level feeds sclk_i from the inverted bus SCLK, so outputs change on the bus falling edge and the receiver samples mid-bit.

Parameters:
WIDTH, 16, sample width in bits per channel
SLOT_BITS, 32, bit clocks per channel slot; must be >= WIDTH. Frame length is 2*SLOT_BITS.

Ports:
sclk_i  input  1  bit clock; all state updates on its rising edge
rst_n_i  input  1  asynchronous active-low reset
leftChan_i  input  WIDTH  left sample, two's complement
rightChan_i  input  WIDTH  right sample
pktValid_i  input  1  sample pair offered
pktReady_o  output  1  buffer can accept a pair; equals NOT bufFull
ws_o  output  1  word select: 0 = left slot, 1 = right slot
sdata_o  output  1  serial data
frameStart_o  output  1  one-cycle pulse coincident with the ws_o falling edge
underrun_o  output  1  one-cycle pulse when a frame starts with no buffered pair

Behaviour:
- Reset (asynchronous, immediate):
  - ws_o=1, sdata_o=0, frameStart_o=0, underrun_o=0.
  - Bit counter cnt=0, bufFull=0, txLeft=0, txRight=0, buffer registers 0.
  - Handshakes are ignored while rst_n_i is low.
- Counter: cnt has width clog2(2*SLOT_BITS). It increments every edge and wraps from 2*SLOT_BITS-1 to 0.
- Registered outputs: on each edge, ws_o and sdata_o take the values defined for the current cnt, then cnt advances.
- ws_o: 0 when cnt < SLOT_BITS, else 1.
- Frame bit j (0 <= j < 2*SLOT_BITS):
  - Left slot: j < WIDTH gives txLeft[WIDTH-1-j]; WIDTH <= j < SLOT_BITS gives 0.
  - Right slot: SLOT_BITS <= j < SLOT_BITS+WIDTH gives txRight[WIDTH-1-(j-SLOT_BITS)]; remaining positions give 0.
- sdata_o at cnt=k is frame bit (k-1) mod 2*SLOT_BITS (the one-bit delay).
  - At cnt=0 the delay bit is the last bit of the previous right slot, taken from the old txRight before reload. It equals txRight[0] when SLOT_BITS==WIDTH, else 0.
- Frame start edge (cnt==0):
  - frameStart_o=1.
  - If bufFull: txLeft/txRight load from the buffer, bufFull clears.
  - Else: txLeft/txRight load 0 (mute) and underrun_o=1.
- Handshake:
  - Transfer occurs on an edge where pktValid_i && pktReady_o. It captures leftChan_i/rightChan_i and sets bufFull.
  - The pair is not consumed in the same edge's frame load (no bypass).
  - A pair offered while the buffer is full holds until the next cnt==0 edge drains it; pktReady_o rises the cycle after that edge.
- Latency: a pair accepted before the cnt==0 edge of frame N is loaded at that edge. Its left MSB appears on sdata_o at the cnt=1 edge.
- Sustained throughput: one pair per 2*SLOT_BITS clocks.
- Outputs are compatible with I2Srx: that module ignores the delay bit and latches left on the ws rise and right on the ws fall.

Test Plan (WIDTH=16, SLOT_BITS=32 unless stated):
1. Reset, no pktValid_i -> ws_o low 32 / high 32 cycles repeating; sdata_o all 0; frameStart_o and underrun_o pulse every 64 cycles.
2. Offer L=0xA5C3, R=0x0F0F before a frame -> sdata_o at cnt 1..16 = 1010010111000011, cnt 17..32 = 0, cnt 33..48 = 0000111100001111, cnt 49..63 and next cnt 0 = 0; no underrun.
3. Back-to-back offers of pairs P1 and P2 -> P1 accepted immediately. pktReady_o stays low until one cycle after the next cnt==0 edge, then P2 is accepted. P1 and P2 are serialized in consecutive frames.
4. SLOT_BITS=16, loopback into I2Srx with sequence 0x8001/0x7FFE then 0x0000/0xFFFF -> I2Srx recovers identical left/right words, one pktI2SRxChanged_o per frame. Delay bit at cnt=0 equals the prior right LSB.
5. Assert rst_n_i low at cnt=20 with bufFull=1 -> ws_o=1 and sdata_o=0 with no clock edge. After release: bufFull=0, the first edge emits cnt=0 values, underrun_o pulses.
6. pktValid_i rises on the cnt==0 edge with the buffer empty -> underrun_o=1 and that frame is all zeros. The pair is accepted and transmitted in the following frame.
